// File: rtl/ita_disp_arbiter.sv
// Round-robin shared owner of a 12-digit, 14-segment frame buffer with a free-running digit scanner.
// Optional DISP_TIMEOUT_EN: revoke ownership after MAX_HOLD cycles and mask the revoked requester.
`timescale 1ns/1ps
module ita_disp_arbiter #(
    parameter int NREQ     = 4,
    parameter int DIGITS   = 12,
    parameter int SCAN_DIV = 1,
    parameter int MAX_HOLD = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [13:0]       wr_data,
    output logic              busy,
    output logic              tmo,
    output logic [DIGITS-1:0] sel,
    output logic [13:0]       segm
);
    localparam int PW = $clog2(NREQ);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] PS_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    IDX_LAST = 4'(DIGITS - 1);
    localparam logic [3:0]    DIG_N    = 4'(DIGITS);
    localparam logic [PW-1:0] REQ_LAST = PW'(NREQ - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] gnt_nxt, elig;
    logic [PW-1:0]   owner, owner_nxt, rr_ptr, rr_nxt, pick;
    logic            found;

    logic [13:0]     fbuf [DIGITS];
    logic [SW-1:0]   ps;
    logic [3:0]      idx;

`ifdef DISP_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    logic [HW-1:0]   hold, hold_nxt;
    logic [NREQ-1:0] mask, mask_nxt;
    logic            tmo_nxt;

    assign elig = req & ~mask;
`else
    assign elig = req;
    assign tmo  = 1'b0;
`endif

    assign busy = |gnt;

    // First eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [PW-1:0] k;
        found = 1'b0;
        pick  = '0;
        k     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = PW'((32'(rr_ptr) + i) % 32'(NREQ));
            if (!found && elig[k]) begin
                found = 1'b1;
                pick  = k;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
`ifdef DISP_TIMEOUT_EN
        hold_nxt  = hold;
        mask_nxt  = mask & req;
        tmo_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OWN;
                    gnt_nxt   = NREQ'(1) << pick;
                    owner_nxt = pick;
`ifdef DISP_TIMEOUT_EN
                    hold_nxt  = '0;
`endif
                end
            end
            OWN: begin
                if (!req[owner]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    rr_nxt    = (owner == REQ_LAST) ? '0 : owner + 1'b1;
                end
`ifdef DISP_TIMEOUT_EN
                else if (hold == HOLD_LAST) begin
                    state_nxt       = IDLE;
                    gnt_nxt         = '0;
                    rr_nxt          = (owner == REQ_LAST) ? '0 : owner + 1'b1;
                    tmo_nxt         = 1'b1;
                    mask_nxt[owner] = 1'b1;
                end else begin
                    hold_nxt = hold + 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            owner  <= '0;
            rr_ptr <= '0;
`ifdef DISP_TIMEOUT_EN
            hold   <= '0;
            mask   <= '0;
            tmo    <= 1'b0;
`endif
        end else begin
            gnt    <= gnt_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
`ifdef DISP_TIMEOUT_EN
            hold   <= hold_nxt;
            mask   <= mask_nxt;
            tmo    <= tmo_nxt;
`endif
        end
    end

    // Writes qualify on the registered grant, so a write in the release cycle still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fbuf <= '{default: '0};
        else if (wr_en && (|gnt) && (wr_addr < DIG_N))
            fbuf[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps   <= '0;
            idx  <= '0;
            sel  <= '0;
            segm <= '0;
        end else begin
            sel  <= DIGITS'(1) << idx;
            segm <= fbuf[idx];
            if (ps == PS_LAST) begin
                ps  <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 4'd1;
            end else begin
                ps <= ps + 1'b1;
            end
        end
    end
endmodule

// File: doc/ita_disp_arbiter.md
# ita_disp_arbiter

Shares the 12-digit, 14-segment multiplexed display among up to NREQ independent requesters. A round-robin arbiter grants one requester at a time write ownership of a 12-entry segment frame buffer. A free-running scanner continuously drives the buffer contents onto the one-hot digit select and segment outputs. It replaces hard-wired message patterns: each user project writes its own text into the buffer, and the scanner drives the display pins.

## Interface
- NREQ, 4, number of requesters (2..8)
- DIGITS, 12, number of display digits (1..12); also the width of sel
- SCAN_DIV, 1, clock cycles each digit stays selected (≥1)
- MAX_HOLD, 4096, ownership cycle limit; used only with DISP_TIMEOUT_EN

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester ownership request, level
- gnt  out  NREQ  registered one-hot grant, or all zero
- wr_en  in  1  buffer write strobe; the granted requester drives it
- wr_addr  in  4  digit index 0..DIGITS-1
- wr_data  in  14  segment pattern; bit 13 = segment a … bit 0 = last diagonal
- busy  out  1  high while any gnt bit is set
- tmo  out  1  one-cycle pulse on forced revocation
- sel  out  DIGITS  one-hot digit select
- segm  out  14  segment pattern for the selected digit

## Operation
- Arbiter FSM, states IDLE and OWN:
  - IDLE: if any req bit is set, pick the first set bit searching from rr_ptr upward with wrap. Register gnt one-hot, latch owner, go to OWN.
  - OWN: while req[owner] stays high, hold gnt.
  - OWN, req[owner] low: clear gnt, set rr_ptr = owner+1 mod NREQ, go to IDLE.
  - IDLE always lasts at least 1 cycle between owners, so there is no back-to-back handover.
- Buffer: DIGITS × 14-bit registers.
  - A write is taken when wr_en=1, the registered gnt≠0 and wr_addr<DIGITS.
  - Writes with no active grant, and writes with wr_addr≥DIGITS, are dropped silently.
  - Writes are never merged; the last accepted write wins.
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1.
  - Digit index advances when the prescaler wraps; index goes 0..DIGITS-1, then back to 0.
  - Every cycle: sel <= 1<<index, segm <= buf[index].
- The display is never blanked by arbitration; the buffer keeps its contents across owners.

## Timing
- Reset values: gnt=0, busy=0, tmo=0, sel=0, segm=0, all buffer entries 0 (blank), index=0, prescaler=0, rr_ptr=0, state IDLE.
- Reset asserted mid-ownership clears everything immediately, including any buffer write in flight.
- Grant latency: req sampled high at edge k in IDLE → gnt high after edge k.
- Release latency: req[owner] sampled low at edge k → gnt low after edge k. The earliest next grant is after edge k+1.
- A write presented in the same cycle that gnt is still high is accepted, even if req has already dropped.
- Display latency: a write accepted at edge k is visible on segm at the next selection of that digit, and no earlier than edge k+1.
- If a write targets the digit being driven in the same cycle, segm shows the old value this pass.
- With SCAN_DIV=1 after reset release, the first edge gives sel=…0001, segm=buf[0]. Digit DIGITS-1 appears on edge DIGITS, then the scan wraps to digit 0.
- Simultaneous requests: exactly one grant per arbitration. Priority rotates from rr_ptr.

## Configuration
- DISP_TIMEOUT_EN defined:
  - A hold counter runs in OWN. When the owner reaches MAX_HOLD cycles of ownership, gnt clears and tmo pulses for 1 cycle.
  - rr_ptr advances past the owner and the FSM returns to IDLE.
  - The revoked requester is masked from arbitration until it deasserts req for at least 1 cycle.
- Not defined: no counter and no mask; ownership is unlimited; tmo is tied to 0.

## Test plan
- Reset, no requests, SCAN_DIV=1 → sel walks 0x001→0x800 and wraps to 0x001 every 12 cycles; segm=0; gnt=0.
- req=0b0001; write addr 0 = 14'b11001111000000, addr 1 = 14'b11101111000000 → gnt=0b0001 one cycle after req; segm shows both patterns when sel=0x001 and sel=0x002.
- req=0b1111 held, each owner releases after 3 cycles → grants occur in order 0,1,2,3,0 with 1 IDLE cycle between owners.
- wr_en with gnt=0, and wr_en with wr_addr=12 under a grant → buffer unchanged; segm unchanged across a full scan.
- Assert rst while owning and mid-write → all outputs 0 immediately; buffer blank after release.
- DISP_TIMEOUT_EN, MAX_HOLD=16, req[2] held → gnt[2] drops after 16 cycles with a tmo pulse; req[2] is not regranted until it toggles low.
